// File: rtl/id_ex_reg_pkg.sv
// Shared widths and constants for the decode/execute pipeline register.
// The control bundle is packed so that a bubble is one constant assignment.
package id_ex_reg_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ALU_CTRL_W     = 4;
  localparam int SHIFT_OP_W     = 12;
  localparam int REG_ADDR_W     = 4;
  localparam int BUBBLE_CNT_W   = 16;

  typedef struct packed {
    logic reg_write_enable;
    logic mem_enable;
    logic mem_rw;
    logic mem_to_reg_select;
    logic alu_src_select;
    logic status_bit;
    logic pc_src_select;
    logic mem_size;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;
  localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (v == BUBBLE_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall hold, flush bubble insertion
// and a saturating count of bubbles that entered the stage.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W     = id_ex_reg_pkg::DATA_W_DEFAULT,
  parameter int ALU_CTRL_W = id_ex_reg_pkg::ALU_CTRL_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    reg_write_enable_in,
  input  logic                    mem_enable_in,
  input  logic                    mem_rw_in,
  input  logic                    mem_to_reg_select_in,
  input  logic                    alu_src_select_in,
  input  logic                    status_bit_in,
  input  logic                    pc_src_select_in,
  input  logic                    mem_size_in,
  input  logic [ALU_CTRL_W-1:0]   alu_control_in,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [DATA_W-1:0]       rn_val_in,
  input  logic [DATA_W-1:0]       rm_val_in,
  input  logic [DATA_W-1:0]       rd_store_val_in,
  input  logic [SHIFT_OP_W-1:0]   shift_operand_in,
  input  logic [REG_ADDR_W-1:0]   rd_addr_in,
  input  logic                    valid_in,
  output logic                    reg_write_enable_out,
  output logic                    mem_enable_out,
  output logic                    mem_rw_out,
  output logic                    mem_to_reg_select_out,
  output logic                    alu_src_select_out,
  output logic                    status_bit_out,
  output logic                    pc_src_select_out,
  output logic                    mem_size_out,
  output logic [ALU_CTRL_W-1:0]   alu_control_out,
  output logic [DATA_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       rn_val_out,
  output logic [DATA_W-1:0]       rm_val_out,
  output logic [DATA_W-1:0]       rd_store_val_out,
  output logic [SHIFT_OP_W-1:0]   shift_operand_out,
  output logic [REG_ADDR_W-1:0]   rd_addr_out,
  output logic                    valid_out,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  ctrl_t                   ctrl_d, ctrl_q;
  logic [ALU_CTRL_W-1:0]   alu_q;
  logic [DATA_W-1:0]       pc_q, rn_q, rm_q, rd_store_q;
  logic [SHIFT_OP_W-1:0]   shift_q;
  logic [REG_ADDR_W-1:0]   rd_addr_q;
  logic                    valid_q;
  logic [BUBBLE_CNT_W-1:0] cnt_q;

  assign ctrl_d = '{reg_write_enable:  reg_write_enable_in,
                    mem_enable:        mem_enable_in,
                    mem_rw:            mem_rw_in,
                    mem_to_reg_select: mem_to_reg_select_in,
                    alu_src_select:    alu_src_select_in,
                    status_bit:        status_bit_in,
                    pc_src_select:     pc_src_select_in,
                    mem_size:          mem_size_in};

  // Data fields load on both flush and load edges; only stall holds them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= BUBBLE_CTRL;
      alu_q      <= '0;
      pc_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      rd_store_q <= '0;
      shift_q    <= '0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else if (flush || !stall) begin
      pc_q       <= pc_in;
      rn_q       <= rn_val_in;
      rm_q       <= rm_val_in;
      rd_store_q <= rd_store_val_in;
      shift_q    <= shift_operand_in;
      rd_addr_q  <= rd_addr_in;
      if (flush || !valid_in) begin
        ctrl_q  <= BUBBLE_CTRL;
        alu_q   <= '0;
        valid_q <= 1'b0;
        cnt_q   <= sat_inc(cnt_q);
      end else begin
        ctrl_q  <= ctrl_d;
        alu_q   <= alu_control_in;
        valid_q <= 1'b1;
      end
    end
  end

  assign reg_write_enable_out  = ctrl_q.reg_write_enable;
  assign mem_enable_out        = ctrl_q.mem_enable;
  assign mem_rw_out            = ctrl_q.mem_rw;
  assign mem_to_reg_select_out = ctrl_q.mem_to_reg_select;
  assign alu_src_select_out    = ctrl_q.alu_src_select;
  assign status_bit_out        = ctrl_q.status_bit;
  assign pc_src_select_out     = ctrl_q.pc_src_select;
  assign mem_size_out          = ctrl_q.mem_size;
  assign alu_control_out       = alu_q;
  assign pc_out                = pc_q;
  assign rn_val_out            = rn_q;
  assign rm_val_out            = rm_q;
  assign rd_store_val_out      = rd_store_q;
  assign shift_operand_out     = shift_q;
  assign rd_addr_out           = rd_addr_q;
  assign valid_out             = valid_q;
  assign bubble_count          = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg: a behavioural model tracks expected outputs
// edge by edge and a single process compares every output after each edge.
module tb_id_ex_reg;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall, flush, valid_in;
  logic [7:0]    ctrl_in;
  logic [AW-1:0] alu_in;
  logic [DW-1:0] pc_in, rn_in, rm_in, rds_in;
  logic [11:0]   shift_in;
  logic [3:0]    rd_in;

  logic [7:0]    ctrl_out;
  logic [AW-1:0] alu_out;
  logic [DW-1:0] pc_out, rn_out, rm_out, rds_out;
  logic [11:0]   shift_out;
  logic [3:0]    rd_out;
  logic          valid_out;
  logic [15:0]   cnt_out;

  // Model state: what the stage must hold, by the stated rules.
  logic [7:0]    m_ctrl = '0;
  logic [AW-1:0] m_alu = '0;
  logic [DW-1:0] m_pc = '0, m_rn = '0, m_rm = '0, m_rds = '0;
  logic [11:0]   m_shift = '0;
  logic [3:0]    m_rd = '0;
  logic          m_valid = 1'b0;
  int            m_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW), .ALU_CTRL_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .reg_write_enable_in(ctrl_in[7]), .mem_enable_in(ctrl_in[6]),
    .mem_rw_in(ctrl_in[5]), .mem_to_reg_select_in(ctrl_in[4]),
    .alu_src_select_in(ctrl_in[3]), .status_bit_in(ctrl_in[2]),
    .pc_src_select_in(ctrl_in[1]), .mem_size_in(ctrl_in[0]),
    .alu_control_in(alu_in), .pc_in(pc_in), .rn_val_in(rn_in),
    .rm_val_in(rm_in), .rd_store_val_in(rds_in),
    .shift_operand_in(shift_in), .rd_addr_in(rd_in), .valid_in(valid_in),
    .reg_write_enable_out(ctrl_out[7]), .mem_enable_out(ctrl_out[6]),
    .mem_rw_out(ctrl_out[5]), .mem_to_reg_select_out(ctrl_out[4]),
    .alu_src_select_out(ctrl_out[3]), .status_bit_out(ctrl_out[2]),
    .pc_src_select_out(ctrl_out[1]), .mem_size_out(ctrl_out[0]),
    .alu_control_out(alu_out), .pc_out(pc_out), .rn_val_out(rn_out),
    .rm_val_out(rm_out), .rd_store_val_out(rds_out),
    .shift_operand_out(shift_out), .rd_addr_out(rd_out),
    .valid_out(valid_out), .bubble_count(cnt_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ctrl", 64'(ctrl_out), 64'(m_ctrl));
    check("alu_control", 64'(alu_out), 64'(m_alu));
    check("data", {pc_out, rn_out}, {m_pc, m_rn});
    check("data2", {rm_out, rds_out}, {m_rm, m_rds});
    check("shift_rd", 64'({shift_out, rd_out}), 64'({m_shift, m_rd}));
    check("valid", 64'(valid_out), 64'(m_valid));
    check("bubble_count", 64'(cnt_out), 64'(m_cnt));
  endtask

  always @(negedge reset_n) begin
    m_ctrl = '0; m_alu = '0; m_pc = '0; m_rn = '0; m_rm = '0; m_rds = '0;
    m_shift = '0; m_rd = '0; m_valid = 1'b0; m_cnt = 0;
  end

  // Model update and per-cycle comparison.
  always @(posedge clk) begin
    if (reset_n) begin
      if (flush || !stall) begin
        bit bubble;
        bubble = flush || !valid_in;
        m_pc = pc_in; m_rn = rn_in; m_rm = rm_in; m_rds = rds_in;
        m_shift = shift_in; m_rd = rd_in;
        m_valid = !bubble;
        m_ctrl  = bubble ? 8'h00 : ctrl_in;
        m_alu   = bubble ? '0 : alu_in;
        if (bubble && m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
    #1;
    if (reset_n) compare_all();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_load(input bit v);
    stall = 0; flush = 0; valid_in = v;
  endtask

  task automatic rand_inputs();
    ctrl_in  = 8'($urandom);
    alu_in   = AW'($urandom);
    pc_in    = $urandom; rn_in = $urandom; rm_in = $urandom; rds_in = $urandom;
    shift_in = 12'($urandom);
    rd_in    = 4'($urandom);
    valid_in = ($urandom_range(3) != 0);
    stall    = ($urandom_range(3) == 0);
    flush    = ($urandom_range(7) == 0);
  endtask

  initial begin
    // Reset with every input high: outputs must be zero before any edge.
    stall = 1; flush = 1; valid_in = 1; ctrl_in = '1; alu_in = '1;
    pc_in = '1; rn_in = '1; rm_in = '1; rds_in = '1; shift_in = '1; rd_in = '1;
    #3;
    check("reset_ctrl", 64'(ctrl_out), 64'h0);
    check("reset_valid", 64'(valid_out), 64'h0);
    check("reset_pc", 64'(pc_out), 64'h0);
    check("reset_count", 64'(cnt_out), 64'h0);
    repeat (2) step();
    check("reset_hold_alu", 64'(alu_out), 64'h0);

    // Load: one edge of latency.
    @(negedge clk);
    reset_n = 1;
    set_load(1); ctrl_in = '0; alu_in = 4'b0100; rn_in = 32'h0000_0005; rd_in = 4'd3;
    check("no_comb_path", 64'(alu_out), 64'h0);
    step();
    check("load_alu", 64'(alu_out), 64'h4);
    check("load_rn", 64'(rn_out), 64'h5);
    check("load_valid", 64'(valid_out), 64'h1);

    // Stall holds rd_addr across 3 edges.
    @(negedge clk);
    stall = 1; rd_in = 4'd7;
    repeat (3) step();
    check("stall_rd_addr", 64'(rd_out), 64'd3);
    check("stall_count", 64'(cnt_out), 64'd0);

    // Flush wins over stall; data still loads.
    @(negedge clk);
    stall = 1; flush = 1; ctrl_in = 8'h80; pc_in = 32'h0000_0010;
    step();
    check("flush_rwe", 64'(ctrl_out[7]), 64'h0);
    check("flush_valid", 64'(valid_out), 64'h0);
    check("flush_pc", 64'(pc_out), 64'h10);
    check("flush_count", 64'(cnt_out), 64'd1);

    // Saturation: climb to FFFE, then two more flush edges plus one extra.
    @(negedge clk);
    stall = 0; flush = 1;
    repeat (65533) @(posedge clk);
    #2;
    check("sat_pre", 64'(cnt_out), 64'hFFFE);
    step();
    check("sat_first", 64'(cnt_out), 64'hFFFF);
    step();
    check("sat_second", 64'(cnt_out), 64'hFFFF);
    step();
    check("sat_third", 64'(cnt_out), 64'hFFFF);

    // Reset pulse in the middle of a flush sequence.
    @(negedge clk);
    set_load(1); ctrl_in = 8'hFF; alu_in = 4'h9;
    step();
    @(negedge clk);
    flush = 1;
    reset_n = 0;
    #1;
    check("midflush_reset_ctrl", 64'(ctrl_out), 64'h0);
    check("midflush_reset_alu", 64'(alu_out), 64'h0);
    check("midflush_reset_count", 64'(cnt_out), 64'h0);
    #1;
    reset_n = 1;
    #1;
    check("post_reset_count", 64'(cnt_out), 64'h0);
    step();
    check("post_reset_flush", 64'(cnt_out), 64'd1);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rand_inputs();
      if ($urandom_range(199) == 0) begin
        reset_n = 0;
        #1;
        check("rand_reset_valid", 64'(valid_out), 64'h0);
        check("rand_reset_count", 64'(cnt_out), 64'h0);
        #1;
        reset_n = 1;
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
